// File: rtl/tag_set_store.sv
// Tag store for a set-associative cache: per-set tag/valid arrays, registered
// lookup with hit/multi-hit detection and replacement victim selection.
module tag_set_store #(
    parameter int  WAYS  = 8,
    parameter int  TAG_W = 24,
    parameter int  SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_index,
    input  logic [TAG_W-1:0] lk_tag,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_valid,
    input  logic [IDX_W-1:0] inv_index,
    input  logic [WAY_W-1:0] inv_way,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_hit,
    output logic [WAY_W-1:0] res_way,
    output logic             res_multi,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic [TAG_W-1:0] victim_tag
);

    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_d   [SETS][WAYS];
    logic             valid_q [SETS][WAYS];
    logic             valid_d [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];
    logic [WAY_W-1:0] rr_d    [SETS];

    logic             res_valid_q, res_valid_d;
    logic             res_hit_q, res_hit_d;
    logic [WAY_W-1:0] res_way_q, res_way_d;
    logic             res_multi_q, res_multi_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;
    logic             victim_valid_q, victim_valid_d;
    logic [TAG_W-1:0] victim_tag_q, victim_tag_d;

    logic             fill_ok, inv_ok, free_found;
    logic [WAY_W-1:0] vic_sel;

    assign fill_ok = fill_valid && (int'(fill_way) < WAYS);
    assign inv_ok  = inv_valid && (int'(inv_way) < WAYS);

    // Lookup path reads only the current (pre-update) state.
    always_comb begin
        res_valid_d    = lk_valid;
        res_hit_d      = 1'b0;
        res_way_d      = '0;
        res_multi_d    = 1'b0;
        victim_way_d   = '0;
        victim_valid_d = 1'b0;
        victim_tag_d   = '0;
        free_found     = 1'b0;
        vic_sel        = rr_q[lk_index];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_index][w] && (tag_q[lk_index][w] == lk_tag)) begin
                if (res_hit_d) begin
                    res_multi_d = 1'b1;
                end else begin
                    res_hit_d = 1'b1;
                    res_way_d = WAY_W'(w);
                end
            end
            if (!valid_q[lk_index][w] && !free_found) begin
                free_found = 1'b1;
                vic_sel    = WAY_W'(w);
            end
        end
        if (lk_valid) begin
            victim_way_d   = vic_sel;
            victim_valid_d = valid_q[lk_index][vic_sel];
            victim_tag_d   = tag_q[lk_index][vic_sel];
        end else begin
            res_hit_d   = 1'b0;
            res_way_d   = '0;
            res_multi_d = 1'b0;
        end
    end

    // Invalidate is applied before fill so a fill to the same entry wins.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                rr_d[s] = '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[s][w] = 1'b0;
                end
            end
        end else begin
            if (inv_ok) begin
                valid_d[inv_index][inv_way] = 1'b0;
            end
            if (fill_ok) begin
                tag_d[fill_index][fill_way]   = fill_tag;
                valid_d[fill_index][fill_way] = 1'b1;
                rr_d[fill_index] = (int'(fill_way) == WAYS - 1) ? '0
                                                                : fill_way + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
            res_valid_q    <= 1'b0;
            res_hit_q      <= 1'b0;
            res_way_q      <= '0;
            res_multi_q    <= 1'b0;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_tag_q   <= '0;
        end else begin
            tag_q          <= tag_d;
            valid_q        <= valid_d;
            rr_q           <= rr_d;
            res_valid_q    <= res_valid_d;
            res_hit_q      <= res_hit_d;
            res_way_q      <= res_way_d;
            res_multi_q    <= res_multi_d;
            victim_way_q   <= victim_way_d;
            victim_valid_q <= victim_valid_d;
            victim_tag_q   <= victim_tag_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_hit      = res_hit_q;
    assign res_way      = res_way_q;
    assign res_multi    = res_multi_q;
    assign victim_way   = victim_way_q;
    assign victim_valid = victim_valid_q;
    assign victim_tag   = victim_tag_q;

endmodule
